// File: rtl/vtx1_imem_prefetch.sv
// vtx1_imem_prefetch: sequential VLIW bundle prefetcher between the core fetch
// port and the instruction memory bus. Bundles are fetched ahead into a small
// FIFO; a core request matching the predicted address is served in the same
// cycle, any other address flushes the FIFO and restarts the stream there.

`ifndef VTX1_WORD_WIDTH
`define VTX1_WORD_WIDTH 32
`endif
`ifndef VTX1_VLIW_WIDTH
`define VTX1_VLIW_WIDTH 128
`endif

module vtx1_imem_prefetch #(
   parameter int unsigned           WORD_WIDTH  = `VTX1_WORD_WIDTH,
   parameter int unsigned           VLIW_WIDTH  = `VTX1_VLIW_WIDTH,
   parameter int unsigned           DEPTH       = 4,
   parameter int unsigned           ADDR_STRIDE = 1,
   parameter logic [WORD_WIDTH-1:0] RESET_ADDR  = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [WORD_WIDTH-1:0]  imem_addr,
   input  logic                   imem_req,
   output logic [VLIW_WIDTH-1:0]  imem_data,
   output logic                   imem_ready,
   output logic [WORD_WIDTH-1:0]  mem_addr,
   output logic                   mem_req,
   input  logic [VLIW_WIDTH-1:0]  mem_data,
   input  logic                   mem_ack,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [31:0]            hit_count,
   output logic [31:0]            redirect_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0]      DEPTH_L = LVL_W'(DEPTH);
   localparam logic [WORD_WIDTH-1:0] STRIDE  = WORD_WIDTH'(ADDR_STRIDE);
   localparam logic [31:0]           CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   issue;
   logic                   can_issue;

   logic [WORD_WIDTH-1:0]  expect_addr_q;
   logic [WORD_WIDTH-1:0]  nfa_q;
   logic [WORD_WIDTH-1:0]  nfa_d;
   logic [WORD_WIDTH-1:0]  mem_addr_q;
   logic                   mem_req_q;

   logic [VLIW_WIDTH-1:0]  fifo_mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [LVL_W-1:0]       level_q;
   logic [LVL_W-1:0]       level_d;

   logic [31:0]            hit_cnt_q;
   logic [31:0]            redir_cnt_q;

   logic                   hit;
   logic                   redir;
   logic                   push;

   // Core-side classification of the current request against the predicted stream
   always_comb begin
      hit   = 1'b0;
      redir = 1'b0;
      if (imem_req) begin
         if (imem_addr != expect_addr_q) begin
            redir = 1'b1;
         end else if (level_q != '0) begin
            hit = 1'b1;
         end
      end
   end

   // Returned data is kept only for the live stream; stale or redirected acks drop it
   always_comb begin
      push = (state_q == S_FETCH) && mem_ack && !redir;
   end

   // Level and fetch address as they will be after this edge
   always_comb begin
      level_d = level_q;
      nfa_d   = nfa_q;
      if (redir) begin
         level_d = '0;
         nfa_d   = imem_addr;
      end else begin
         if (push && !hit) begin
            level_d = level_q + LVL_W'(1);
         end else if (hit && !push) begin
            level_d = level_q - LVL_W'(1);
         end
         if (push) begin
            nfa_d = nfa_q + STRIDE;
         end
      end
      can_issue = enable && (level_d < DEPTH_L);
   end

   // Fetch FSM next state; a finishing transaction may chain straight into the next issue
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (can_issue) begin
               state_d = S_FETCH;
               issue   = 1'b1;
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               if (can_issue) begin
                  state_d = S_FETCH;
                  issue   = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (redir) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (mem_ack) begin
               if (can_issue) begin
                  state_d = S_FETCH;
                  issue   = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and memory request registers; the address only moves on a new issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= (state_d != S_IDLE);
         if (issue) begin
            mem_addr_q <= nfa_d;
         end
      end
   end

   // Predicted core address and next fetch address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expect_addr_q <= RESET_ADDR;
         nfa_q         <= RESET_ADDR;
      end else begin
         nfa_q <= nfa_d;
         if (redir) begin
            expect_addr_q <= imem_addr;
         end else if (hit) begin
            expect_addr_q <= expect_addr_q + STRIDE;
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         level_q <= level_d;
         if (redir) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (hit) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

   // Bundle storage; contents are qualified by the level, so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_data;
      end
   end

   // Saturating service and redirect counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q   <= '0;
         redir_cnt_q <= '0;
      end else begin
         if (hit && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (redir && (redir_cnt_q != CNT_MAX)) begin
            redir_cnt_q <= redir_cnt_q + 32'd1;
         end
      end
   end

   // Same-cycle hit response straight from the FIFO head
   always_comb begin
      imem_ready = hit;
      imem_data  = (level_q != '0) ? fifo_mem[rd_ptr_q] : '0;
   end

   assign mem_req        = mem_req_q;
   assign mem_addr       = mem_addr_q;
   assign fifo_level     = level_q;
   assign hit_count      = hit_cnt_q;
   assign redirect_count = redir_cnt_q;

endmodule

// File: tb/tb_vtx1_imem_prefetch.sv
// Self-checking bench for vtx1_imem_prefetch: table of core fetches with a
// data scoreboard, plus hand sequences for redirect, drain, full and reset cases.
module tb_vtx1_imem_prefetch;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [31:0]   imem_addr;
   logic          imem_req;
   logic [127:0]  imem_data;
   logic          imem_ready;
   logic [31:0]   mem_addr;
   logic          mem_req;
   logic [127:0]  mem_data;
   logic          mem_ack;
   logic [2:0]    fifo_level;
   logic [31:0]   hit_count;
   logic [31:0]   redirect_count;

   // memory model: automatic (latency mem_lat) or driven by hand sequences
   logic          manual;
   logic          man_ack;
   logic [127:0]  man_data;
   logic          auto_ack;
   logic [127:0]  auto_data;
   int unsigned   mem_lat;
   int unsigned   lat_cnt;

   int            checks;
   int            errors;
   logic [127:0]  sb [$];
   logic [31:0]   addr_log [$];

   assign mem_ack  = manual ? man_ack  : auto_ack;
   assign mem_data = manual ? man_data : auto_data;

   vtx1_imem_prefetch #(
      .WORD_WIDTH(32), .VLIW_WIDTH(128), .DEPTH(4), .ADDR_STRIDE(1), .RESET_ADDR(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_data(imem_data), .imem_ready(imem_ready),
      .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_data(mem_data), .mem_ack(mem_ack),
      .fifo_level(fifo_level), .hit_count(hit_count), .redirect_count(redirect_count)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
      $fatal(1);
   end

   function automatic logic [127:0] bundle_of(input logic [31:0] a);
      return {a ^ 32'hA5A5_0000, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
   endfunction

   // automatic memory: ack comes mem_lat cycles after the request first appears
   initial begin
      auto_ack  = 1'b0;
      auto_data = '0;
      lat_cnt   = 0;
      forever begin
         @(negedge clk);
         if (auto_ack) begin
            auto_ack = 1'b0;
            lat_cnt  = 0;
         end
         if (!manual && mem_req) begin
            lat_cnt = lat_cnt + 1;
            if (lat_cnt > mem_lat) begin
               auto_ack  = 1'b1;
               auto_data = bundle_of(mem_addr);
               addr_log.push_back(mem_addr);
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // sample the combinational response each cycle until ready or budget expires
   task automatic wait_ready(input int max_wait, output int n);
      logic         got;
      logic [127:0] e;
      got = 1'b0;
      n   = -1;
      for (int i = 0; i <= max_wait; i++) begin
         #2;
         if (imem_ready) begin
            got = 1'b1;
            n   = i;
            e   = (sb.size() != 0) ? sb.pop_front() : '0;
            chk("imem_data", imem_data, e);
         end
         @(negedge clk);
         if (got) break;
      end
      chk("imem_ready_seen", got, 1'b1);
      if (!got && sb.size() != 0) void'(sb.pop_front());
   endtask

   task automatic core_fetch(input logic [31:0] a, input int max_wait, output int n);
      imem_req  = 1'b1;
      imem_addr = a;
      sb.push_back(bundle_of(a));
      wait_ready(max_wait, n);
      imem_req = 1'b0;
   endtask

   task automatic wait_req(input int max_wait, output logic ok);
      ok = 1'b0;
      for (int i = 0; i <= max_wait; i++) begin
         if (mem_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic drive_ack();
      man_ack  = 1'b1;
      man_data = bundle_of(mem_addr);
      @(negedge clk);
      man_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      imem_req = 1'b0;
      man_ack  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [31:0] addr;
      int          max_wait;
      logic [31:0] hits;
      logic [31:0] redirs;
   } vec_t;

   vec_t vt [9];

   initial begin
      int   n;
      logic ok;
      checks = 0; errors = 0;
      vt[0] = '{32'h00, 0,  32'd1, 32'd0};
      vt[1] = '{32'h01, 0,  32'd2, 32'd0};
      vt[2] = '{32'h02, 0,  32'd3, 32'd0};
      vt[3] = '{32'h03, 0,  32'd4, 32'd0};
      vt[4] = '{32'h04, 10, 32'd5, 32'd0};
      vt[5] = '{32'h05, 10, 32'd6, 32'd0};
      vt[6] = '{32'h40, 12, 32'd7, 32'd1};
      vt[7] = '{32'h41, 10, 32'd8, 32'd1};
      vt[8] = '{32'h07, 12, 32'd9, 32'd2};

      // reset values
      manual = 1'b0; man_ack = 1'b0; man_data = '0; mem_lat = 1;
      enable = 1'b1; rst_n = 1'b0; imem_req = 1'b1; imem_addr = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_level", fifo_level, 3'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_redirs", redirect_count, 32'd0);
      chk("rst_ready", imem_ready, 1'b0);
      chk("rst_data", imem_data, 128'h0);
      imem_req = 1'b0;
      rst_n = 1'b1;
      #2 chk("req_low_release_cycle", mem_req, 1'b0);
      @(negedge clk);
      chk("first_req", mem_req, 1'b1);
      chk("first_addr", mem_addr, 32'h0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (fifo_level == 3'd4 && !mem_req) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("fill_to_4_idle", ok, 1'b1);
      chk("fetch_count", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("fetch_addr_seq", addr_log[i], 32'(i));
      addr_log.delete();

      // table: hits, refills and redirects with data scoreboard
      for (int i = 0; i < 9; i++) begin
         core_fetch(vt[i].addr, vt[i].max_wait, n);
         chk("tbl_hit_count", hit_count, vt[i].hits);
         chk("tbl_redirect_count", redirect_count, vt[i].redirs);
      end

      // redirect to 0x40 from a full, idle buffer
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (fifo_level == 3'd4 && !mem_req) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("refill_idle", ok, 1'b1);
      imem_req = 1'b1; imem_addr = 32'h40; sb.push_back(bundle_of(32'h40));
      #2 chk("redir40_not_ready", imem_ready, 1'b0);
      @(negedge clk);
      chk("redir40_level", fifo_level, 3'd0);
      chk("redir40_req", mem_req, 1'b1);
      chk("redir40_addr", mem_addr, 32'h40);
      chk("redir40_count", redirect_count, 32'd3);
      wait_ready(6, n);
      chk("redir40_latency", n, 2);
      imem_req = 1'b0;

      // redirect to 0x80 while fetch of 0x2 is pending, 3-cycle memory
      mem_lat = 3;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req && mem_addr == 32'h2) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("pending_2_seen", ok, 1'b1);
      imem_req = 1'b1; imem_addr = 32'h80; sb.push_back(bundle_of(32'h80));
      #2 chk("redir80_not_ready", imem_ready, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("drain_req", mem_req, 1'b1);
         chk("drain_addr", mem_addr, 32'h2);
         chk("drain_level", fifo_level, 3'd0);
      end
      @(negedge clk);
      chk("post_drain_addr", mem_addr, 32'h80);
      chk("post_drain_req", mem_req, 1'b1);
      chk("post_drain_level", fifo_level, 3'd0);
      chk("redir80_count", redirect_count, 32'd1);
      wait_ready(8, n);
      chk("redir80_latency", n, 4);
      imem_req = 1'b0;
      mem_lat = 1;

      // redirect in the same cycle as the ack
      manual = 1'b1;
      do_reset();
      wait_req(4, ok);
      chk("same_cycle_req", ok, 1'b1);
      chk("same_cycle_addr0", mem_addr, 32'h0);
      man_ack = 1'b1; man_data = bundle_of(mem_addr);
      imem_req = 1'b1; imem_addr = 32'hC0; sb.push_back(bundle_of(32'hC0));
      #2 chk("same_cycle_not_ready", imem_ready, 1'b0);
      @(negedge clk);
      man_ack = 1'b0;
      chk("same_cycle_level", fifo_level, 3'd0);
      chk("same_cycle_new_req", mem_req, 1'b1);
      chk("same_cycle_new_addr", mem_addr, 32'hC0);
      chk("same_cycle_redirs", redirect_count, 32'd1);
      man_ack = 1'b1; man_data = bundle_of(mem_addr);
      #2 chk("c0_not_yet_ready", imem_ready, 1'b0);
      @(negedge clk);
      man_ack = 1'b0;
      wait_ready(1, n);
      chk("c0_latency", n, 0);
      imem_req = 1'b0;

      // full buffer, pop frees space, push+pop keeps level and order
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wait_req(4, ok);
         chk("full_fill_req", ok, 1'b1);
         chk("full_fill_addr", mem_addr, 32'(i));
         drive_ack();
      end
      chk("full_idle_req", mem_req, 1'b0);
      chk("full_level", fifo_level, 3'd4);
      core_fetch(32'h0, 0, n);
      chk("pop_level", fifo_level, 3'd3);
      chk("pop_issue_req", mem_req, 1'b1);
      chk("pop_issue_addr", mem_addr, 32'h4);
      man_ack = 1'b1; man_data = bundle_of(mem_addr);
      core_fetch(32'h1, 0, n);
      man_ack = 1'b0;
      chk("pushpop_level", fifo_level, 3'd3);
      chk("pushpop_req", mem_req, 1'b1);
      chk("pushpop_addr", mem_addr, 32'h5);
      drive_ack();
      chk("refull_level", fifo_level, 3'd4);
      chk("refull_req", mem_req, 1'b0);
      for (int a = 2; a <= 5; a++) core_fetch(32'(a), 0, n);
      chk("full_hits", hit_count, 32'd6);

      // reset mid-FETCH, late ack after release
      chk("mid_fetch_req", mem_req, 1'b1);
      imem_req = 1'b1; imem_addr = 32'h2;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_req", mem_req, 1'b0);
      chk("midrst_mem_addr", mem_addr, 32'h0);
      chk("midrst_level", fifo_level, 3'd0);
      chk("midrst_hits", hit_count, 32'd0);
      chk("midrst_redirs", redirect_count, 32'd0);
      chk("midrst_ready", imem_ready, 1'b0);
      chk("midrst_data", imem_data, 128'h0);
      imem_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      enable = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("disabled_no_req", mem_req, 1'b0);
      enable = 1'b1;
      man_ack = 1'b1; man_data = {4{32'hDEAD_BEEF}};
      @(negedge clk);
      man_ack = 1'b0;
      chk("late_ack_level", fifo_level, 3'd0);
      chk("post_rst_req", mem_req, 1'b1);
      chk("post_rst_addr", mem_addr, 32'h0);
      drive_ack();
      core_fetch(32'h0, 0, n);
      chk("post_rst_hits", hit_count, 32'd1);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
